// File: rtl/fpu_dispatch_unit.sv
// Issue stage for the FPU ALU execution element: owns the FP register file, latches operands,
// arms the element through its reset, and writes results back one op at a time.
module fpu_dispatch_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TIMER_WIDTH    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_inst_num,
  input  logic [4:0]  req_fs_idx,
  input  logic [4:0]  req_ft_idx,
  input  logic [4:0]  req_fd_idx,
  input  logic        ext_we,
  input  logic [4:0]  ext_idx,
  input  logic [31:0] ext_data,
  input  logic [4:0]  rd_idx,
  output logic [31:0] rd_data,
  output logic        exec_reset,
  output logic [5:0]  exec_inst_num,
  output logic [31:0] exec_fs,
  output logic [31:0] exec_ft,
  input  logic        exec_completed,
  input  logic [31:0] exec_out,
  output logic        done,
  output logic        done_wb,
  output logic        done_err,
  output logic [4:0]  done_fd,
  output logic [31:0] done_value
);

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned OP_W     = 6;

  localparam logic [OP_W-1:0] FP_OP_FIRST = OP_W'(54);
  localparam bit WATCHDOG_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_EXEC
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0]      regs [NUM_REGS];
  logic [IDX_W-1:0]       fd_q, fd_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;

  logic                   accept;
  logic                   is_fp_op;
  logic                   timeout;
  logic [DATA_W-1:0]      fs_val, ft_val;

  logic                   req_ready_d, exec_reset_d;
  logic                   done_d, done_wb_d, done_err_d;
  logic [IDX_W-1:0]       done_fd_d;
  logic [DATA_W-1:0]      done_value_d;
  logic [OP_W-1:0]        inst_d;
  logic [DATA_W-1:0]      fs_d, ft_d;
  logic                   wb_en;

  assign accept   = req_valid && req_ready;
  // A 6-bit opcode cannot exceed 63, so the lower bound alone selects 54..63.
  assign is_fp_op = (exec_inst_num >= FP_OP_FIRST);
  assign timeout  = WATCHDOG_EN && (timer_q == TIMER_LAST);

  // Operand read with same-edge bypass from the external load path.
  assign fs_val = (ext_we && (ext_idx == req_fs_idx)) ? ext_data : regs[req_fs_idx];
  assign ft_val = (ext_we && (ext_idx == req_ft_idx)) ? ext_data : regs[req_ft_idx];

  assign rd_data = regs[rd_idx];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_EXEC;
      S_EXEC: if (exec_completed || timeout) state_d = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath.
  always_comb begin
    req_ready_d  = (state_d == S_IDLE);
    exec_reset_d = (state_d == S_IDLE);
    done_d       = 1'b0;
    done_wb_d    = 1'b0;
    done_err_d   = 1'b0;
    done_fd_d    = done_fd;
    done_value_d = done_value;
    inst_d       = exec_inst_num;
    fs_d         = exec_fs;
    ft_d         = exec_ft;
    fd_d         = fd_q;
    timer_d      = timer_q;
    wb_en        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          inst_d  = req_inst_num;
          fs_d    = fs_val;
          ft_d    = ft_val;
          fd_d    = req_fd_idx;
          timer_d = '0;
        end
      end
      S_EXEC: begin
        if (exec_completed) begin
          done_d    = 1'b1;
          done_fd_d = fd_q;
          if (is_fp_op) begin
            wb_en        = 1'b1;
            done_wb_d    = 1'b1;
            done_value_d = exec_out;
          end else begin
            done_value_d = '0;
          end
        end else if (timeout) begin
          done_d       = 1'b1;
          done_err_d   = 1'b1;
          done_fd_d    = fd_q;
          done_value_d = '0;
        end else begin
          timer_d = timer_q + TIMER_WIDTH'(1);
        end
      end
    endcase
  end

  // Registered outputs and op context.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready     <= 1'b1;
      exec_reset    <= 1'b1;
      done          <= 1'b0;
      done_wb       <= 1'b0;
      done_err      <= 1'b0;
      done_fd       <= '0;
      done_value    <= '0;
      exec_inst_num <= '0;
      exec_fs       <= '0;
      exec_ft       <= '0;
      fd_q          <= '0;
      timer_q       <= '0;
    end else begin
      req_ready     <= req_ready_d;
      exec_reset    <= exec_reset_d;
      done          <= done_d;
      done_wb       <= done_wb_d;
      done_err      <= done_err_d;
      done_fd       <= done_fd_d;
      done_value    <= done_value_d;
      exec_inst_num <= inst_d;
      exec_fs       <= fs_d;
      exec_ft       <= ft_d;
      fd_q          <= fd_d;
      timer_q       <= timer_d;
    end
  end

  // Register file; writeback is ordered last so it wins over a same-index load.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (ext_we) regs[ext_idx] <= ext_data;
      if (wb_en) regs[fd_q] <= exec_out;
    end
  end

endmodule

// File: doc/fpu_dispatch_unit.md
Name: fpu_dispatch_unit

Overview:
Upstream issue stage for the FPU ALU execution element. It owns the 32x32 FP register file and accepts FP ops from decode over a valid/ready handshake. It reads and latches operands, arms the execution element through that element's reset, waits for its `completed`, then writes the result back to fd. It runs one op at a time, with a completion pulse and a watchdog timeout.

Parameters:
TIMEOUT_CYCLES, 256, max EXEC-state cycles before abort; 0 disables the watchdog
TIMER_WIDTH, 16, width of the EXEC cycle counter; must be able to hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  decode presents an op
req_ready  out  1  unit idle, op acceptable
req_inst_num  in  6  instruction number (54..63 = FP ALU ops)
req_fs_idx  in  5  source register fs
req_ft_idx  in  5  source register ft
req_fd_idx  in  5  destination register fd
ext_we  in  1  external FP register write (load path)
ext_idx  in  5  external write index
ext_data  in  32  external write data
rd_idx  in  5  debug read index
rd_data  out  32  combinational regfile[rd_idx]
exec_reset  out  1  drives the execution element's reset
exec_inst_num  out  6  latched inst_num to the element
exec_fs  out  32  latched fs operand
exec_ft  out  32  latched ft operand
exec_completed  in  1  element's completed
exec_out  in  32  element's result
done  out  1  one-cycle pulse: op finished
done_wb  out  1  valid with done: fd was written
done_err  out  1  valid with done: watchdog abort
done_fd  out  5  valid with done: destination index
done_value  out  32  valid with done: value written (0 if no write)

Behaviour:
- States: IDLE, EXEC.
- Reset values:
  - state=IDLE, req_ready=1, exec_reset=1.
  - done, done_wb, done_err = 0.
  - done_fd=0, done_value=0, exec_inst_num/fs/ft=0, timer=0.
  - All 32 registers cleared to 0.
- exec_reset is registered: 1 in IDLE, 0 in EXEC. The element is held cleared while idle, so its completed is 0 at the start of EXEC.
- IDLE, on req_valid && req_ready at edge E0:
  - Latch inst_num, fd, fs=reg[fs_idx], ft=reg[ft_idx].
  - Bypass: if ext_we at E0 and ext_idx matches fs_idx or ft_idx, the latched operand takes ext_data.
  - Set state=EXEC, exec_reset<=0, req_ready<=0, timer<=0.
- Latched operands stay stable for the whole of EXEC. Later register writes do not affect them.
- EXEC, each edge:
  - If exec_completed=1: done<=1 and state<=IDLE, exec_reset<=1, req_ready<=1.
    - If inst_num in 54..63: reg[fd]<=exec_out, done_wb<=1, done_value<=exec_out.
    - Otherwise: done_wb<=0, done_value<=0, no write.
  - Else if TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1: done<=1, done_err<=1, done_wb<=0, no write, return to IDLE.
  - Else timer<=timer+1.
- Latency: single-cycle element ops (MOV/ABS/NEG/unknown) complete at E1, are sampled at E2, and done is high in the cycle after E2 (3 edges accept-to-done). A new op can be accepted on the edge ending the done cycle.
- done, done_wb and done_err are single-cycle pulses. done_fd and done_value hold until the next done.
- Register writes:
  - ext_we writes in any state.
  - If writeback and ext_we hit the same index on the same edge, writeback wins.
  - Register 0 is an ordinary register (no hardwired zero).
- rd_data is combinational from current register contents, with no bypass.
- Reset mid-EXEC: the op is abandoned with no writeback and no done, and all reset values apply on that edge. exec_reset=1 then clears the element.
- req_valid while req_ready=0 is ignored. Decode must hold the request.

Test Plan:
1. ext write f1=0x3F800000; issue MOV.S(62) fs=1 fd=2 -> done 3 edges after accept, done_wb=1, done_fd=2, rd_data[2]=0x3F800000.
2. f3=0x40000000; NEG.S(55) fs=3 fd=3 -> done_value=0xC0000000, reg3=0xC0000000. Back-to-back ABS.S(54) fs=3 fd=4 accepted the cycle after done -> reg4=0x40000000.
3. Unknown inst_num=10 -> done with done_wb=0, done_value=0, no register changed. Also ext_we to f5 on the accept edge of MOV.S fs=5 -> bypassed value used.
4. Stub element never completing, TIMEOUT_CYCLES=8 -> done_err=1 exactly 8 EXEC edges after accept, no write, exec_reset=1, req_ready=1 after.
5. Stub completing after 20 cycles with exec_out=0x12345678 and ext_we to fd on the same edge -> reg[fd]=0x12345678 (writeback wins).
6. Assert reset at EXEC cycle 2 of a 20-cycle op -> no done, req_ready=1, exec_reset=1, all registers read 0.
